// File: rtl/ps2_pkg.sv
// Shared constants, state encoding and event layout for the PS/2 Set-2 scan code decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  localparam logic [7:0] PS2_ACK     = 8'hFA;
  localparam logic [7:0] PS2_RESEND  = 8'hFE;
  localparam logic [7:0] PS2_ECHO    = 8'hEE;
  localparam logic [7:0] PS2_BAT_OK  = 8'hAA;
  localparam logic [7:0] PS2_BAT_ERR = 8'hFC;
  localparam logic [7:0] PS2_ERR0    = 8'h00;
  localparam logic [7:0] PS2_ERRF    = 8'hFF;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_E0    = 3'd1;
  localparam logic [2:0] ST_F0    = 3'd2;
  localparam logic [2:0] ST_E0F0  = 3'd3;
  localparam logic [2:0] ST_PAUSE = 3'd4;

  // The pause key sends E1 followed by seven bytes; the skip counter ends on index 6.
  localparam logic [2:0] PAUSE_TAIL_LAST = 3'd6;

  localparam int EV_WIDTH    = 10;
  localparam int EV_CODE_LSB = 0;
  localparam int EV_CODE_MSB = 7;
  localparam int EV_REL_BIT  = 8;
  localparam int EV_EXT_BIT  = 9;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ps2_event_t;

  function automatic logic is_response(input logic [7:0] b);
    logic hit;
    case (b)
      PS2_ACK, PS2_RESEND, PS2_ECHO, PS2_BAT_OK,
      PS2_BAT_ERR, PS2_ERR0, PS2_ERRF: hit = 1'b1;
      default:                         hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic ps2_event_t make_event(input logic ext, input logic rel,
                                            input logic [7:0] code);
    ps2_event_t ev;
    ev.ext  = ext;
    ev.rel  = rel;
    ev.code = code;
    return ev;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through synchronous FIFO holding decoded key events.
module ps2_event_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       rd,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_rd;
  logic             do_wr;

  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign count = cnt;

  // When full, a write is still accepted if the head is popped on the same edge;
  // it lands in the slot being vacated, since both pointers coincide.
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);

  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers are exactly AW bits wide, so DEPTH being a power of two gives free wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Folds PS/2 Set-2 prefix sequences into single key events, queues them, and reports device responses.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    received_data,
  input  logic                          received_data_en,
  input  logic                          ev_rd,
  input  logic                          ovf_clr,
  output logic                          ev_valid,
  output logic [7:0]                    ev_code,
  output logic                          ev_extended,
  output logic                          ev_release,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic                          overflow,
  output logic                          resp_valid,
  output logic [7:0]                    resp_code,
  output logic                          seq_timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]          state;
  logic [2:0]          state_next;
  logic [2:0]          skip;
  logic [2:0]          skip_next;
  logic [TW-1:0]       tout_cnt;
  logic [TW-1:0]       tout_next;
  logic                tout_hit;
  logic                resp_hit;
  logic                emit;
  ps2_event_t          ev_in;
  logic [EV_WIDTH-1:0] head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                drop;

  // Byte decode, pause skipping and the inter-byte silence watchdog.
  // A strobe always takes priority over the watchdog reaching its terminal count.
  always_comb begin
    state_next = state;
    skip_next  = skip;
    tout_next  = tout_cnt;
    tout_hit   = 1'b0;
    resp_hit   = 1'b0;
    emit       = 1'b0;
    ev_in      = make_event(1'b0, 1'b0, 8'h00);
    if (received_data_en) begin
      tout_next = '0;
      case (state)
        ST_IDLE: begin
          if (received_data == PS2_EXT) begin
            state_next = ST_E0;
          end else if (received_data == PS2_BRK) begin
            state_next = ST_F0;
          end else if (received_data == PS2_PAUSE) begin
            state_next = ST_PAUSE;
            skip_next  = '0;
          end else if (is_response(received_data)) begin
            resp_hit = 1'b1;
          end else begin
            emit  = 1'b1;
            ev_in = make_event(1'b0, 1'b0, received_data);
          end
        end
        ST_E0: begin
          if (received_data == PS2_BRK) begin
            state_next = ST_E0F0;
          end else if (received_data != PS2_EXT) begin
            emit       = 1'b1;
            ev_in      = make_event(1'b1, 1'b0, received_data);
            state_next = ST_IDLE;
          end
        end
        ST_F0: begin
          emit       = 1'b1;
          ev_in      = make_event(1'b0, 1'b1, received_data);
          state_next = ST_IDLE;
        end
        ST_E0F0: begin
          emit       = 1'b1;
          ev_in      = make_event(1'b1, 1'b1, received_data);
          state_next = ST_IDLE;
        end
        ST_PAUSE: begin
          if (skip == PAUSE_TAIL_LAST) begin
            emit       = 1'b1;
            ev_in      = make_event(1'b1, 1'b0, PS2_PAUSE);
            state_next = ST_IDLE;
            skip_next  = '0;
          end else begin
            skip_next = skip + 1'b1;
          end
        end
        default: begin
          state_next = ST_IDLE;
          skip_next  = '0;
        end
      endcase
    end else if (state != ST_IDLE) begin
      if (tout_cnt == TOUT_LAST) begin
        tout_hit   = 1'b1;
        tout_next  = '0;
        state_next = ST_IDLE;
        skip_next  = '0;
      end else begin
        tout_next = tout_cnt + 1'b1;
      end
    end else begin
      tout_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      skip        <= '0;
      tout_cnt    <= '0;
      resp_valid  <= 1'b0;
      resp_code   <= 8'h00;
      seq_timeout <= 1'b0;
    end else begin
      state       <= state_next;
      skip        <= skip_next;
      tout_cnt    <= tout_next;
      resp_valid  <= resp_hit;
      seq_timeout <= tout_hit;
      if (resp_hit) begin
        resp_code <= received_data;
      end
    end
  end

  // An event is lost only when the queue is full and nothing leaves on the same edge.
  assign drop = emit && fifo_full && !ev_rd;

  // Sticky drop flag; a fresh drop outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EV_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (emit),
    .wdata (ev_in),
    .rd    (ev_rd),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (ev_count)
  );

  assign ev_valid    = !fifo_empty;
  assign ev_code     = head[EV_CODE_MSB:EV_CODE_LSB];
  assign ev_release  = head[EV_REL_BIT];
  assign ev_extended = head[EV_EXT_BIT];

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed self-checking bench for ps2_scancode_decoder with a shortened watchdog period.
module tb_ps2_scancode_decoder;

  localparam int DEPTH = 16;
  localparam int TOUT  = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] received_data = 8'h00;
  logic       received_data_en = 1'b0;
  logic       ev_rd = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_extended;
  logic       ev_release;
  logic [4:0] ev_count;
  logic       overflow;
  logic       resp_valid;
  logic [7:0] resp_code;
  logic       seq_timeout;

  int checks = 0;
  int errors = 0;

  ps2_scancode_decoder #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .received_data    (received_data),
    .received_data_en (received_data_en),
    .ev_rd            (ev_rd),
    .ovf_clr          (ovf_clr),
    .ev_valid         (ev_valid),
    .ev_code          (ev_code),
    .ev_extended      (ev_extended),
    .ev_release       (ev_release),
    .ev_count         (ev_count),
    .overflow         (overflow),
    .resp_valid       (resp_valid),
    .resp_code        (resp_code),
    .seq_timeout      (seq_timeout)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge; callers sit on a negedge.
  task automatic send_byte(input logic [7:0] b);
    received_data    = b;
    received_data_en = 1'b1;
    @(negedge clk);
    received_data_en = 1'b0;
  endtask

  task automatic pop_event();
    ev_rd = 1'b1;
    @(negedge clk);
    ev_rd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ev_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_ev_valid got=%b exp=0", ev_valid); end
    checks++;
    if (ev_count !== 5'd0) begin errors++; $display("[TB] FAIL reset_ev_count got=%0d exp=0", ev_count); end
    checks++;
    if ({ev_extended, ev_release, ev_code} !== 10'h000) begin
      errors++; $display("[TB] FAIL reset_head got=%h exp=000", {ev_extended, ev_release, ev_code});
    end
    checks++;
    if ({overflow, resp_valid, seq_timeout} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_flags got=%b exp=000", {overflow, resp_valid, seq_timeout});
    end
    checks++;
    if (resp_code !== 8'h00) begin errors++; $display("[TB] FAIL reset_resp_code got=%h exp=00", resp_code); end
  endtask

  task automatic test_make_break();
    checks++;
    if (ev_valid !== 1'b0) begin errors++; $display("[TB] FAIL mb_pre_valid got=%b exp=0", ev_valid); end
    send_byte(8'h1C);
    checks++;
    if (ev_valid !== 1'b1) begin errors++; $display("[TB] FAIL mb_latency got=%b exp=1", ev_valid); end
    idle(100);
    send_byte(8'hF0);
    idle(100);
    send_byte(8'h1C);
    idle(100);
    checks++;
    if (ev_count !== 5'd2) begin errors++; $display("[TB] FAIL mb_count got=%0d exp=2", ev_count); end
    checks++;
    if ({ev_extended, ev_release, ev_code} !== 10'h01C) begin
      errors++; $display("[TB] FAIL mb_make got=%h exp=01c", {ev_extended, ev_release, ev_code});
    end
    pop_event();
    checks++;
    if ({ev_extended, ev_release, ev_code} !== 10'h11C) begin
      errors++; $display("[TB] FAIL mb_break got=%h exp=11c", {ev_extended, ev_release, ev_code});
    end
    pop_event();
    checks++;
    if (ev_valid !== 1'b0) begin errors++; $display("[TB] FAIL mb_drained got=%b exp=0", ev_valid); end
  endtask

  task automatic test_extended();
    logic [7:0] seq [5];
    logic       resp_seen;
    seq[0] = 8'hE0; seq[1] = 8'h75; seq[2] = 8'hE0; seq[3] = 8'hF0; seq[4] = 8'h75;
    resp_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_byte(seq[i]);
      if (resp_valid) resp_seen = 1'b1;
      idle(3);
    end
    checks++;
    if (resp_seen !== 1'b0) begin errors++; $display("[TB] FAIL ext_no_resp got=%b exp=0", resp_seen); end
    checks++;
    if (ev_count !== 5'd2) begin errors++; $display("[TB] FAIL ext_count got=%0d exp=2", ev_count); end
    checks++;
    if ({ev_extended, ev_release, ev_code} !== 10'h275) begin
      errors++; $display("[TB] FAIL ext_make got=%h exp=275", {ev_extended, ev_release, ev_code});
    end
    pop_event();
    checks++;
    if ({ev_extended, ev_release, ev_code} !== 10'h375) begin
      errors++; $display("[TB] FAIL ext_break got=%h exp=375", {ev_extended, ev_release, ev_code});
    end
    pop_event();
  endtask

  task automatic test_pause();
    logic [7:0] seq [8];
    seq[0] = 8'hE1; seq[1] = 8'h14; seq[2] = 8'h77; seq[3] = 8'hE1;
    seq[4] = 8'hF0; seq[5] = 8'h14; seq[6] = 8'hF0; seq[7] = 8'h77;
    for (int i = 0; i < 7; i++) send_byte(seq[i]);
    checks++;
    if (ev_count !== 5'd0) begin errors++; $display("[TB] FAIL pause_early got=%0d exp=0", ev_count); end
    send_byte(seq[7]);
    checks++;
    if (ev_count !== 5'd1) begin errors++; $display("[TB] FAIL pause_one got=%0d exp=1", ev_count); end
    send_byte(8'h1C);
    checks++;
    if ({ev_extended, ev_release, ev_code} !== 10'h2E1) begin
      errors++; $display("[TB] FAIL pause_event got=%h exp=2e1", {ev_extended, ev_release, ev_code});
    end
    pop_event();
    checks++;
    if ({ev_extended, ev_release, ev_code} !== 10'h01C) begin
      errors++; $display("[TB] FAIL pause_next got=%h exp=01c", {ev_extended, ev_release, ev_code});
    end
    pop_event();
  endtask

  task automatic test_response();
    send_byte(8'hFA);
    checks++;
    if ({resp_valid, resp_code} !== 9'h1FA) begin
      errors++; $display("[TB] FAIL resp_pulse got=%h exp=1fa", {resp_valid, resp_code});
    end
    checks++;
    if (ev_count !== 5'd0) begin errors++; $display("[TB] FAIL resp_count got=%0d exp=0", ev_count); end
    idle(1);
    checks++;
    if ({resp_valid, resp_code} !== 9'h0FA) begin
      errors++; $display("[TB] FAIL resp_hold got=%h exp=0fa", {resp_valid, resp_code});
    end
  endtask

  task automatic test_timeout();
    send_byte(8'hE0);
    idle(TOUT - 1);
    checks++;
    if (seq_timeout !== 1'b0) begin errors++; $display("[TB] FAIL tout_early got=%b exp=0", seq_timeout); end
    idle(1);
    checks++;
    if (seq_timeout !== 1'b1) begin errors++; $display("[TB] FAIL tout_pulse got=%b exp=1", seq_timeout); end
    idle(1);
    checks++;
    if (seq_timeout !== 1'b0) begin errors++; $display("[TB] FAIL tout_end got=%b exp=0", seq_timeout); end
    send_byte(8'h1C);
    checks++;
    if ({ev_extended, ev_release, ev_code} !== 10'h01C) begin
      errors++; $display("[TB] FAIL tout_after got=%h exp=01c", {ev_extended, ev_release, ev_code});
    end
    pop_event();
    // Strobe arriving on the terminal-count cycle must be decoded, not timed out.
    send_byte(8'hE0);
    idle(TOUT - 1);
    send_byte(8'h75);
    checks++;
    if (seq_timeout !== 1'b0) begin errors++; $display("[TB] FAIL tout_race got=%b exp=0", seq_timeout); end
    checks++;
    if ({ev_valid, ev_extended, ev_release, ev_code} !== 11'h675) begin
      errors++; $display("[TB] FAIL tout_race_ev got=%h exp=675", {ev_valid, ev_extended, ev_release, ev_code});
    end
    pop_event();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 17; i++) send_byte(8'h10 + 8'(i));
    checks++;
    if (ev_count !== 5'd16) begin errors++; $display("[TB] FAIL ovf_count got=%0d exp=16", ev_count); end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set got=%b exp=1", overflow); end
    checks++;
    if (ev_code !== 8'h10) begin errors++; $display("[TB] FAIL ovf_head got=%h exp=10", ev_code); end
    ev_rd = 1'b1;
    send_byte(8'h21);
    ev_rd = 1'b0;
    checks++;
    if ({ev_count, ev_code} !== {5'd16, 8'h11}) begin
      errors++; $display("[TB] FAIL ovf_wr_rd got=%0d/%h exp=16/11", ev_count, ev_code);
    end
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear got=%b exp=0", overflow); end
    ev_rd = 1'b1;
    send_byte(8'h22);
    ev_rd = 1'b0;
    checks++;
    if ({overflow, ev_count, ev_code} !== {1'b0, 5'd16, 8'h12}) begin
      errors++; $display("[TB] FAIL ovf_full_pop got=%b/%0d/%h exp=0/16/12", overflow, ev_count, ev_code);
    end
    ovf_clr = 1'b1;
    send_byte(8'h23);
    ovf_clr = 1'b0;
    checks++;
    if ({overflow, ev_count, ev_code} !== {1'b1, 5'd16, 8'h12}) begin
      errors++; $display("[TB] FAIL ovf_set_wins got=%b/%0d/%h exp=1/16/12", overflow, ev_count, ev_code);
    end
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_byte(8'h1C); send_byte(8'h1B); send_byte(8'h23);
    send_byte(8'hE0);
    checks++;
    if (ev_count !== 5'd3) begin errors++; $display("[TB] FAIL rst_pre_count got=%0d exp=3", ev_count); end
    do_reset();
    checks++;
    if ({ev_valid, ev_count} !== 6'd0) begin
      errors++; $display("[TB] FAIL rst_mid got=%b/%0d exp=0/0", ev_valid, ev_count);
    end
    send_byte(8'h75);
    checks++;
    if ({ev_valid, ev_extended, ev_release, ev_code} !== 11'h475) begin
      errors++; $display("[TB] FAIL rst_next got=%h exp=475", {ev_valid, ev_extended, ev_release, ev_code});
    end
  endtask

  task automatic test_empty_read();
    pop_event();
    checks++;
    if ({ev_valid, ev_count} !== 6'd0) begin
      errors++; $display("[TB] FAIL empty_pop1 got=%b/%0d exp=0/0", ev_valid, ev_count);
    end
    pop_event();
    send_byte(8'h2B);
    checks++;
    if ({ev_count, ev_code} !== {5'd1, 8'h2B}) begin
      errors++; $display("[TB] FAIL empty_pop2 got=%0d/%h exp=1/2b", ev_count, ev_code);
    end
    pop_event();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_make_break();
    test_extended();
    test_pause();
    test_response();
    test_timeout();
    test_overflow();
    test_reset_mid();
    test_empty_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog got=running exp=finished");
    $fatal(1, "[TB] time limit reached");
  end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
Downstream consumer of the PS/2 byte receiver. Takes each received byte (received_data with the one-cycle received_data_en strobe) and folds keyboard Set-2 prefix sequences (E0, F0, E0 F0, E1 pause) into single key events. Key events are buffered in a first-word-fall-through FIFO for the CPU/bus side. Device response bytes are reported separately and are not queued.

Parameters:
FIFO_DEPTH, 16, event FIFO entries; power of two, >=2
TIMEOUT_CYCLES, 500000, clk cycles of inter-byte silence before an incomplete prefix sequence is abandoned (10 ms at 50 MHz)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
received_data  in  8  byte from PS/2 receiver, valid while received_data_en=1
received_data_en  in  1  one-cycle strobe, new byte
ev_rd  in  1  pop FIFO head; ignored when ev_valid=0
ovf_clr  in  1  clears sticky overflow
ev_valid  out  1  FIFO non-empty
ev_code  out  8  head event scan code
ev_extended  out  1  head event had E0 prefix (or is pause)
ev_release  out  1  head event is key release (F0)
ev_count  out  $clog2(FIFO_DEPTH)+1  entries held
overflow  out  1  sticky: event dropped because FIFO full
resp_valid  out  1  one-cycle pulse, device response byte seen
resp_code  out  8  last response byte, held until next
seq_timeout  out  1  one-cycle pulse, prefix sequence abandoned

Behaviour:
- Reset: reset, synchronous, active-high; clock clk. Reset forces state IDLE, FIFO empty, ev_count=0, ev_valid=0, head outputs 0, overflow=0, resp_valid=0, resp_code=0x00, seq_timeout=0, timeout and skip counters 0. Reset mid-sequence discards the partial sequence and emits nothing.
- All decode is evaluated on the clk edge where received_data_en=1. A resulting event is written on that same edge; ev_valid rises the following cycle, i.e. 1-cycle latency from the strobe.
- States: IDLE, E0, F0, E0F0, PAUSE.
- IDLE: 0xE0 -> E0. 0xF0 -> F0. 0xE1 -> PAUSE with skip=0. Response set {0x00,0xAA,0xEE,0xFA,0xFC,0xFE,0xFF} -> resp_code<=byte, resp_valid pulse, stay IDLE. Any other byte emits {ext=0,rel=0,code}.
- E0: 0xF0 -> E0F0. 0xE0 -> stay E0. Any other byte emits {1,0,code} -> IDLE.
- F0: any byte emits {0,1,code} -> IDLE.
- E0F0: any byte emits {1,1,code} -> IDLE.
- PAUSE: consumes exactly 7 further bytes without inspecting them. On the 7th, emits {1,0,0xE1} -> IDLE. skip counter is 3 bits.
- Timeout: in any non-IDLE state, the counter increments each cycle without a strobe and clears on a strobe. When it reaches TIMEOUT_CYCLES-1 with no strobe: -> IDLE, seq_timeout pulse, nothing emitted, counter cleared. The counter is held at 0 in IDLE. A strobe in the same cycle as terminal count wins: the byte is decoded and there is no timeout.
- FIFO: entry = {ext,rel,code}, 10 bits. FWFT: head outputs are valid whenever ev_valid=1. ev_rd with ev_valid=1 pops at the clock edge.
- Write while full without pop: event dropped, overflow<=1, count unchanged.
- Write and pop in the same cycle: both performed, count unchanged. This applies when full as well (no overflow).
- ev_rd while empty: no effect, no underflow.
- Pointers wrap modulo FIFO_DEPTH. ev_count ranges 0..FIFO_DEPTH.
- overflow is sticky. ovf_clr clears it. If ovf_clr coincides with a new drop, overflow stays 1 (set wins).
- When empty, head outputs show 0 (don't-care for checking; specified as 0).

Decomposition:
- Shared package ps2_pkg holds:
  - byte constants PS2_EXT=0xE0, PS2_BRK=0xF0, PS2_PAUSE=0xE1
  - response codes ACK 0xFA, RESEND 0xFE, ECHO 0xEE, BAT_OK 0xAA, BAT_ERR 0xFC, ERR0 0x00, ERRF 0xFF
  - decoder state encoding (3 bits)
  - event entry width (10) and field offsets
- One sub-module: ps2_event_fifo (parameterised FWFT sync FIFO with wr/rd/full/empty/count). The decoder FSM, timeout and response logic stay in the top module.

Test Plan:
- Bytes 0x1C; 0xF0,0x1C, each strobe 1 cycle, 100-cycle gaps -> two events {0,0,0x1C} then {0,1,0x1C}; ev_valid 1 cycle after first strobe.
- 0xE0,0x75 then 0xE0,0xF0,0x75 -> {1,0,0x75}, {1,1,0x75}; no resp_valid.
- Pause 0xE1,0x14,0x77,0xE1,0xF0,0x14,0xF0,0x77 -> exactly one event {1,0,0xE1}; next byte 0x1C -> {0,0,0x1C}.
- 0xFA in IDLE -> resp_valid pulse, resp_code=0xFA, ev_count unchanged. 0xE0 followed by TIMEOUT_CYCLES idle cycles -> seq_timeout pulse at cycle TIMEOUT_CYCLES; then 0x1C -> {0,0,0x1C}.
- 17 key bytes with no ev_rd (depth 16) -> ev_count=16, overflow=1, head is first byte. Then strobe plus ev_rd in the same cycle -> count stays 16. ovf_clr -> overflow=0.
- Reset asserted after 0xE0 and with 3 entries queued -> ev_valid=0, ev_count=0. Next 0x75 -> {0,0,0x75}.
